// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port SRAM (1-cycle read latency, active-low write enable)
// between the instruction-fetch port and the data-memory port of the core.
// One SRAM access is issued per cycle.
//
// Arbitration:
//   - Data has default priority so the MEM stage drains before fetch.
//   - If fetch has been denied STARVE_LIMIT cycles in a row, fetch wins.
// Read data is routed back to the granted port one cycle after the grant.
// Each rdata output holds its last returned value.
// An optional clear sequencer zeroes every SRAM word after reset, before the
// first grant is issued.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   if_req/if_addr        fetch read request and word address
//   if_gnt                fetch access issued this cycle
//   if_rvalid/if_rdata    fetch read return (cycle after if_gnt)
//   dm_req/dm_we/dm_addr/dm_wdata
//                         data request, write flag, word address, write data
//   dm_gnt                data access issued this cycle
//   dm_rvalid/dm_rdata    data read return (cycle after a read dm_gnt)
//   stall_if, stall_mem   requester is waiting (request without grant)
//   init_done             arbiter is in normal operation
//   sram_a/sram_d/sram_wen/sram_q
//                         SRAM address, write data, active-low write enable
//                         and read data
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              init_done,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d,
   output logic              sram_wen,
   input  logic [DATA_W-1:0] sram_q
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam state_e     RST_STATE  = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                if_pend_q, if_pend_d;
   logic                dm_pend_q, dm_pend_d;
   logic [DATA_W-1:0]   if_hold_q, if_hold_d;
   logic [DATA_W-1:0]   dm_hold_q, dm_hold_d;
   logic                if_force;

   // Grants, SRAM drive and clear sequencing. Everything is gated by rst so
   // that the outputs take their reset values the moment rst falls, even in
   // RUN (CLEAR_ON_RESET=0) where the state register alone would allow grants.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      if_force  = 1'b0;
      sram_a    = '0;
      sram_d    = '0;
      sram_wen  = 1'b1;

      if (rst) begin
         case (state_q)
            ST_INIT: begin
               sram_a    = clr_cnt_q;
               sram_wen  = 1'b0;
               clr_cnt_d = clr_cnt_q + 1'b1;
               if (clr_cnt_q == '1) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if_force = if_req && (starve_cnt_q == STARVE_MAX);
               if (if_force) begin
                  if_gnt = 1'b1;
               end else if (dm_req) begin
                  dm_gnt = 1'b1;
               end else if (if_req) begin
                  if_gnt = 1'b1;
               end

               if (if_gnt) begin
                  sram_a = if_addr;
               end else if (dm_gnt) begin
                  sram_a   = dm_addr;
                  sram_d   = dm_wdata;
                  sram_wen = ~dm_we;
               end
            end
            default: begin
               state_d = RST_STATE;
            end
         endcase
      end
   end

   // Starvation counter saturates so a long INIT with if_req held cannot wrap
   // it past the forced-priority threshold.
   always_comb begin
      starve_cnt_d = '0;
      if (if_req && !if_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                     : starve_cnt_q + 1'b1;
      end
   end

   // Return tags: writes set no tag, so no rvalid follows a write grant.
   always_comb begin
      if_pend_d = if_gnt;
      dm_pend_d = dm_gnt & ~dm_we;
      if_hold_d = if_pend_q ? sram_q : if_hold_q;
      dm_hold_d = dm_pend_q ? sram_q : dm_hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RST_STATE;
         clr_cnt_q    <= '0;
         starve_cnt_q <= '0;
         if_pend_q    <= 1'b0;
         dm_pend_q    <= 1'b0;
         if_hold_q    <= '0;
         dm_hold_q    <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         if_pend_q    <= if_pend_d;
         dm_pend_q    <= dm_pend_d;
         if_hold_q    <= if_hold_d;
         dm_hold_q    <= dm_hold_d;
      end
   end

   // Returned data bypasses the hold register in the return cycle so the
   // requester sees it the cycle after the grant.
   assign if_rvalid = if_pend_q;
   assign dm_rvalid = dm_pend_q;
   assign if_rdata  = if_pend_q ? sram_q : if_hold_q;
   assign dm_rdata  = dm_pend_q ? sram_q : dm_hold_q;

   assign stall_if  = if_req & ~if_gnt;
   assign stall_mem = dm_req & ~dm_gnt;
   assign init_done = rst & (state_q == ST_RUN);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, rst0;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;

   // Main DUT (clear on reset)
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall_if, stall_mem, init_done, sram_wen;
   logic [DW-1:0] if_rdata, dm_rdata, sram_d, sram_q;
   logic [AW-1:0] sram_a;
   // Second DUT (no clear on reset)
   logic          if_gnt0, if_rvalid0, dm_gnt0, dm_rvalid0, stall_if0, stall_mem0, init_done0, sram_wen0;
   logic [DW-1:0] if_rdata0, dm_rdata0, sram_d0, sram_q0;
   logic [AW-1:0] sram_a0;

   logic [DW-1:0] mem  [16];
   logic [DW-1:0] mem0 [16];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      sram_q <= mem[sram_a];
   end

   always @(posedge clk) begin
      if (!sram_wen0) mem0[sram_a0] <= sram_d0;
      sram_q0 <= mem0[sram_a0];
   end

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .init_done(init_done),
      .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q)
   );

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b0)) dut0 (
      .clk(clk), .rst(rst0),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt0), .dm_rvalid(dm_rvalid0), .dm_rdata(dm_rdata0),
      .stall_if(stall_if0), .stall_mem(stall_mem0), .init_done(init_done0),
      .sram_a(sram_a0), .sram_d(sram_d0), .sram_wen(sram_wen0), .sram_q(sram_q0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst0 = 1'b1;
      if_req = 1'b1; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      #2;
      rst = 1'b0; rst0 = 1'b0;
      #1;
      n_checks++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, init_done} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got gnt/rv/done=%b required 00000",
                  {if_gnt, dm_gnt, if_rvalid, dm_rvalid, init_done});
      end
      step(); step();
      n_checks++;
      if ({sram_wen, sram_a, sram_d, if_rdata, dm_rdata} !== {1'b1, {AW{1'b0}}, {3*DW{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_sram: got wen=%b a=%h d=%h ifr=%h dmr=%h required wen=1 rest 0",
                  sram_wen, sram_a, sram_d, if_rdata, dm_rdata);
      end
      n_checks++;
      if ({stall_if, stall_mem} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_stall: got %b required 10", {stall_if, stall_mem});
      end
      n_checks++;
      if ({if_gnt0, init_done0, stall_if0, sram_wen0} !== 4'b0011) begin
         n_fail++;
         $display("FAIL reset_run_gate: got gnt/done/stall/wen=%b required 0011",
                  {if_gnt0, init_done0, stall_if0, sram_wen0});
      end
   endtask

   task automatic test_init();
      int bad = 0;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if ({sram_wen, sram_a, sram_d, if_gnt, dm_gnt, stall_if, init_done} !==
             {1'b0, 4'(k), {DW{1'b0}}, 4'b0010}) begin
            n_fail++;
            bad++;
            $display("FAIL init_cycle%0d: got wen=%b a=%0d d=%h gnt=%b%b stall=%b done=%b required wen=0 a=%0d d=0 gnt=00 stall=1 done=0",
                     k, sram_wen, sram_a, sram_d, if_gnt, dm_gnt, stall_if, init_done, k);
         end
         step();
      end
      n_checks++;
      if ({init_done, if_gnt, sram_wen} !== 3'b111) begin
         n_fail++;
         $display("FAIL init_exit: got done/if_gnt/wen=%b required 111", {init_done, if_gnt, sram_wen});
      end
      step();
      if_req = 1'b0;
      #1;
      n_checks++;
      if ({if_rvalid, if_rdata} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL init_zeroed_read: got rvalid=%b rdata=%h required 1 00000000", if_rvalid, if_rdata);
      end
   endtask

   task automatic test_if_read();
      // Preload word 5 through the data port.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 4'd5; dm_wdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({dm_gnt, sram_wen, sram_a, sram_d} !== {2'b10, 4'd5, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL preload_write: got gnt=%b wen=%b a=%0d d=%h required 1 0 5 deadbeef",
                  dm_gnt, sram_wen, sram_a, sram_d);
      end
      step();
      dm_req = 1'b0; dm_we = 1'b0;
      if_req = 1'b1; if_addr = 4'd5;
      #1;
      n_checks++;
      if ({if_gnt, sram_a, sram_wen, dm_rvalid} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL if_grant: got gnt=%b a=%0d wen=%b dm_rvalid=%b required 1 5 1 0",
                  if_gnt, sram_a, sram_wen, dm_rvalid);
      end
      step();
      if_req = 1'b0;
      #1;
      n_checks++;
      if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL if_return: got rvalid=%b rdata=%h required 1 deadbeef", if_rvalid, if_rdata);
      end
      step();
      n_checks++;
      if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL if_hold: got rvalid=%b rdata=%h required 0 deadbeef", if_rvalid, if_rdata);
      end
   endtask

   task automatic test_dm_priority();
      if_req = 1'b1; if_addr = 4'd2;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 4'd3; dm_wdata = 32'h12345678;
      #1;
      n_checks++;
      if ({dm_gnt, if_gnt, sram_wen, stall_if, stall_mem, sram_a} !== {5'b10010, 4'd3}) begin
         n_fail++;
         $display("FAIL dm_priority: got dm/if/wen/stall_if/stall_mem=%b a=%0d required 10010 3",
                  {dm_gnt, if_gnt, sram_wen, stall_if, stall_mem}, sram_a);
      end
      step();
      dm_req = 1'b0; dm_we = 1'b0;
      #1;
      n_checks++;
      if ({if_gnt, dm_rvalid, sram_a, stall_if} !== {2'b10, 4'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL if_after_dm: got if_gnt=%b dm_rvalid=%b a=%0d stall_if=%b required 1 0 2 0",
                  if_gnt, dm_rvalid, sram_a, stall_if);
      end
      step();
      if_req = 1'b0;
      #1;
      n_checks++;
      if ({if_rvalid, if_rdata, dm_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL if_return2: got rvalid=%b rdata=%h dm_rvalid=%b required 1 00000000 0",
                  if_rvalid, if_rdata, dm_rvalid);
      end
   endtask

   task automatic test_write_read();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 4'd3;
      #1;
      n_checks++;
      if ({dm_gnt, sram_wen, sram_a} !== {2'b11, 4'd3}) begin
         n_fail++;
         $display("FAIL dm_read_grant: got gnt=%b wen=%b a=%0d required 1 1 3", dm_gnt, sram_wen, sram_a);
      end
      step();
      dm_req = 1'b0;
      #1;
      n_checks++;
      if ({dm_rvalid, dm_rdata, if_rvalid} !== {1'b1, 32'h12345678, 1'b0}) begin
         n_fail++;
         $display("FAIL dm_return: got rvalid=%b rdata=%h if_rvalid=%b required 1 12345678 0",
                  dm_rvalid, dm_rdata, if_rvalid);
      end
      step();
      n_checks++;
      if ({dm_rvalid, dm_rdata} !== {1'b0, 32'h12345678}) begin
         n_fail++;
         $display("FAIL dm_hold: got rvalid=%b rdata=%h required 0 12345678", dm_rvalid, dm_rdata);
      end
   endtask

   task automatic test_starve();
      logic exp_if;
      if_req = 1'b1; if_addr = 4'd1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 4'd3;
      #1;
      for (int c = 1; c <= 15; c++) begin
         exp_if = (c % 5 == 0);
         n_checks++;
         if ({if_gnt, dm_gnt, stall_if, stall_mem} !== {exp_if, ~exp_if, ~exp_if, exp_if}) begin
            n_fail++;
            $display("FAIL starve_cycle%0d: got if/dm/stall_if/stall_mem=%b required %b",
                     c, {if_gnt, dm_gnt, stall_if, stall_mem}, {exp_if, ~exp_if, ~exp_if, exp_if});
         end
         step();
      end
      if_req = 1'b0; dm_req = 1'b0;
      step();
   endtask

   task automatic test_reset_midaccess();
      rst0 = 1'b1;
      #1;
      n_checks++;
      if ({init_done0, if_rvalid0, sram_wen0} !== 3'b101) begin
         n_fail++;
         $display("FAIL norun_start: got done/rvalid/wen=%b required 101", {init_done0, if_rvalid0, sram_wen0});
      end
      if_req = 1'b1; if_addr = 4'd7;
      #1;
      n_checks++;
      if ({if_gnt0, sram_a0} !== {1'b1, 4'd7}) begin
         n_fail++;
         $display("FAIL norun_grant: got gnt=%b a=%0d required 1 7", if_gnt0, sram_a0);
      end
      step();
      if_req = 1'b0;
      #1;
      n_checks++;
      if (if_rvalid0 !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_rvalid: got %b required 1", if_rvalid0);
      end
      rst0 = 1'b0;
      #1;
      n_checks++;
      if ({if_rvalid0, if_rdata0, init_done0} !== {1'b0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got rvalid=%b rdata=%h done=%b required 0 00000000 0",
                  if_rvalid0, if_rdata0, init_done0);
      end
      if_req = 1'b1;
      #1;
      n_checks++;
      if ({if_gnt0, stall_if0, sram_wen0} !== 3'b011) begin
         n_fail++;
         $display("FAIL reset_req_blocked: got gnt/stall/wen=%b required 011", {if_gnt0, stall_if0, sram_wen0});
      end
      if_req = 1'b0;
      step();
      rst0 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if (if_rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_rvalid_cycle%0d: got %b required 0", c, if_rvalid0);
         end
      end
      if_req = 1'b1;
      #1;
      n_checks++;
      if (if_gnt0 !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_grant: got %b required 1", if_gnt0);
      end
      step();
      if_req = 1'b0;
      #1;
      n_checks++;
      if (if_rvalid0 !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_rvalid: got %b required 1", if_rvalid0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_init();
      test_if_read();
      test_dm_priority();
      test_write_read();
      test_starve();
      test_reset_midaccess();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port 32-bit SRAM (XSPRAMLP_2048X32_M8P class, 1-cycle read latency, active-low write enable) between the instruction-fetch port and the data-memory port of the 5-stage pipeline core. It issues one SRAM access per cycle using same-cycle grants and routes read data back one cycle later. Losing requesters get per-port stall outputs for the PC/IF-ID and EX/MEM stall logic. An optional post-reset clear sequencer zeroes the whole SRAM before the first grant.

Parameters:
ADDR_W, 11, word-address width; DEPTH = 2**ADDR_W
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied IF cycles before IF gets forced priority (1..15)
CLEAR_ON_RESET, 1, 1 = zero all SRAM words after reset before normal operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch access issued this cycle
if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  data access issued this cycle
dm_rvalid  out  1  dm_rdata valid (cycle after a read dm_gnt)
dm_rdata  out  DATA_W  data read data
stall_if  out  1  if_req & ~if_gnt
stall_mem  out  1  dm_req & ~dm_gnt
init_done  out  1  high in RUN state
sram_a  out  ADDR_W  SRAM address
sram_d  out  DATA_W  SRAM write data
sram_wen  out  1  SRAM write enable, active-low
sram_q  in  DATA_W  SRAM read data, valid cycle after address

Behaviour:
- FSM states: INIT, RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- While rst is low, all of the following hold immediately, without waiting for clk:
  - if_gnt, dm_gnt, if_rvalid and dm_rvalid are 0.
  - sram_wen is 1; sram_a, sram_d, if_rdata and dm_rdata are 0.
  - Starvation counter and clear counter are 0; init_done is 0.
  - stall_if = if_req and stall_mem = dm_req.
- INIT state:
  - sram_a = clr_cnt, sram_d = 0, sram_wen = 0.
  - clr_cnt increments each cycle, 0 to DEPTH-1.
  - After the write at DEPTH-1, go to RUN on the next edge. INIT lasts exactly DEPTH cycles.
  - No grants are issued; init_done = 0.
- RUN state: grants are combinational from the requests and the registered starve flag. At most one grant per cycle.
  - Forced IF: starve_cnt == STARVE_LIMIT and if_req → if_gnt.
  - Otherwise dm_req → dm_gnt; else if_req → if_gnt.
  - Data has default priority so the MEM stage drains before fetch.
- SRAM drive in RUN:
  - if_gnt: sram_a = if_addr, sram_wen = 1.
  - dm_gnt: sram_a = dm_addr, sram_d = dm_wdata, sram_wen = ~dm_we.
  - No grant: sram_a = 0, sram_d = 0, sram_wen = 1.
- Starvation counter (registered, saturating at STARVE_LIMIT):
  - Increments when if_req & ~if_gnt.
  - Clears when if_gnt or ~if_req.
- Read return:
  - A registered tag {if_pend, dm_pend} is set by if_gnt, or by dm_gnt & ~dm_we.
  - Next cycle the tagged rvalid is 1 and the matching rdata = sram_q.
  - A write grant sets no tag, so no rvalid follows it.
- Each rdata output holds its last returned value, via a hold register loaded when its rvalid is 1.
- Back-to-back grants are legal every cycle. The return for grant N and the issue of grant N+1 occur in the same cycle.
- Addresses are used as given; no wrap or range check, since ADDR_W bits cover DEPTH.
- Requesters must hold req, addr, we and wdata stable until granted.
- Reset asserted mid-access: a pending return is discarded, and no rvalid appears after reset releases.

Test Plan:
1. ADDR_W=4, CLEAR_ON_RESET=1, release rst with if_req=1 → sram_wen=0 for 16 cycles with sram_a 0..15 and sram_d=0; stall_if=1 and no grants throughout; init_done=1 in cycle 17, with if_gnt=1 in that same cycle.
2. RUN, SRAM word 5 preloaded 0xDEADBEEF; if_req with if_addr=5 → if_gnt=1 and sram_a=5 the same cycle; next cycle if_rvalid=1 and if_rdata=0xDEADBEEF; if_rdata holds after if_rvalid drops.
3. Same cycle: if_req (addr 2) and dm write (addr 3, 0x12345678) → dm_gnt=1, sram_wen=0, stall_if=1, no dm_rvalid; next cycle with dm_req=0 → if_gnt=1.
4. dm write to addr 3 with 0x12345678, then dm read of addr 3 → dm_rvalid=1 one cycle after the read grant, with dm_rdata=0x12345678.
5. STARVE_LIMIT=4, dm_req and if_req held high continuously → dm_gnt in cycles 1–4 and if_gnt in cycle 5; dm_gnt resumes in cycle 6; pattern repeats every 5 cycles.
6. Assert rst low in the cycle after an if_gnt → if_rvalid=0 immediately with no clk edge; after release (CLEAR_ON_RESET=0), no rvalid until a new grant.
